// File: rtl/uart_tx_fifo_pkg.sv
// Shared definitions for the UART transmit path.
//  UART_DATA_W : default byte width, matches the uart_tx data width
//  state_t     : drain FSM states of uart_tx_fifo
package uart_tx_fifo_pkg;

  localparam int UART_DATA_W = 8;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WAIT_HI = 2'd1,
    S_WAIT_LO = 2'd2
  } state_t;

endpackage

// File: rtl/uart_tx_fifo_mem.sv
// Storage array for uart_tx_fifo: DEPTH x DATA_W register file with one
// synchronous write port and one asynchronous read port. Storage is not reset.
//  clk      : system clock
//  wr_en    : write strobe (already qualified by the owner, e.g. not full)
//  wr_addr  : write address
//  wr_data  : write data
//  rd_addr  : read address
//  rd_data  : combinational read data at rd_addr
module uart_tx_fifo_mem #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
) (
  input  logic                       clk,
  input  logic                       wr_en,
  input  logic [$clog2(DEPTH)-1:0]   wr_addr,
  input  logic [DATA_W-1:0]          wr_data,
  input  logic [$clog2(DEPTH)-1:0]   rd_addr,
  output logic [DATA_W-1:0]          rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Async read lets the drain FSM launch a byte the cycle after it is written.
  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/uart_tx_fifo.sv
// Byte buffer and launch controller in front of uart_tx. Producers write bytes
// at any rate; the drain FSM hands them to uart_tx one at a time using the
// tx_start / tx_data / tx_busy handshake.
//  clk       : system clock
//  rst_n     : asynchronous reset, active-low (discards all buffered data)
//  wr_en     : write strobe, one byte per cycle
//  wr_data   : byte to enqueue
//  full      : FIFO holds DEPTH entries
//  empty     : FIFO holds no entries
//  count     : occupancy 0..DEPTH
//  overflow  : sticky, set when a write is attempted while full
//  ovf_clr   : clears overflow (a simultaneous overflowing write wins)
//  tx_busy   : frame in progress, from uart_tx
//  tx_start  : single-cycle launch pulse to uart_tx
//  tx_data   : byte to uart_tx, held from one tx_start to the next
module uart_tx_fifo
  import uart_tx_fifo_pkg::*;
#(
  parameter  int DATA_W    = UART_DATA_W,
  parameter  int DEPTH     = 16,
  parameter  int BUSY_WAIT = 4,
  localparam int ADDR_W    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  input  logic              ovf_clr,
  input  logic              tx_busy,
  output logic              tx_start,
  output logic [DATA_W-1:0] tx_data
);

  localparam int WAIT_W = ($clog2(BUSY_WAIT + 1) > 0) ? $clog2(BUSY_WAIT + 1) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST  = WAIT_W'(BUSY_WAIT);
  localparam logic [ADDR_W:0]   FULL_COUNT = (ADDR_W + 1)'(DEPTH);

  state_t              state_reg;
  logic [ADDR_W-1:0]   wr_ptr_reg;
  logic [ADDR_W-1:0]   rd_ptr_reg;
  logic [WAIT_W-1:0]   wait_cnt_reg;
  logic [ADDR_W:0]     count_next;
  logic [DATA_W-1:0]   rd_data;
  logic                wr_accept;
  logic                pop;

  // A write while full is refused even if a pop happens in the same cycle.
  assign wr_accept = wr_en && !full;
  assign pop       = (state_reg == S_IDLE) && !empty && !tx_busy;

  always_comb begin
    count_next = count;
    case ({wr_accept, pop})
      2'b10:   count_next = count + 1'b1;
      2'b01:   count_next = count - 1'b1;
      default: count_next = count;
    endcase
  end

  uart_tx_fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk     (clk),
    .wr_en   (wr_accept),
    .wr_addr (wr_ptr_reg),
    .wr_data (wr_data),
    .rd_addr (rd_ptr_reg),
    .rd_data (rd_data)
  );

  // Occupancy, flags and write side.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      count      <= '0;
      full       <= 1'b0;
      empty      <= 1'b1;
      overflow   <= 1'b0;
    end else begin
      count <= count_next;
      full  <= (count_next == FULL_COUNT);
      empty <= (count_next == '0);
      if (wr_accept) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (wr_en && full) begin
        overflow <= 1'b1;
      end else if (ovf_clr) begin
        overflow <= 1'b0;
      end
    end
  end

  // Drain FSM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= S_IDLE;
      rd_ptr_reg   <= '0;
      wait_cnt_reg <= '0;
      tx_start     <= 1'b0;
      tx_data      <= '0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (pop) begin
            tx_data      <= rd_data;
            tx_start     <= 1'b1;
            rd_ptr_reg   <= rd_ptr_reg + 1'b1;
            wait_cnt_reg <= '0;
            state_reg    <= S_WAIT_HI;
          end
        end
        S_WAIT_HI: begin
          tx_start <= 1'b0;
          if (tx_busy) begin
            state_reg <= S_WAIT_LO;
          end else if (!tx_start) begin
            // The pulse cycle itself is not counted: uart_tx only samples
            // tx_start on that edge, so busy cannot appear any earlier. This
            // also keeps launches at least 3 cycles apart on a timeout.
            if (wait_cnt_reg == WAIT_LAST) begin
              state_reg <= S_IDLE;
            end else begin
              wait_cnt_reg <= wait_cnt_reg + 1'b1;
            end
          end
        end
        S_WAIT_LO: begin
          if (!tx_busy) begin
            state_reg <= S_IDLE;
          end
        end
        default: begin
          state_reg <= S_IDLE;
          tx_start  <= 1'b0;
        end
      endcase
    end
  end

endmodule
